// File: rtl/mod_exp_rtm.sv
// mod_exp_rtm: runtime-modulus modular exponentiator, z = x^y mod m.
// Left-to-right binary square-and-multiply; each modular product comes from a
// bit-serial interleaved multiplier that consumes one multiplier bit per cycle.
// Works for any modulus m >= 2 (odd or even) with no precomputed constants.
module mod_exp_rtm #(
  parameter int K    = 196,
  parameter int LOGK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic [K-1:0] m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [K-1:0] z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [K-1:0]    ZERO_K   = {K{1'b0}};
  localparam logic [K-1:0]    ONE_K    = {{(K-1){1'b0}}, 1'b1};
  localparam logic [K+1:0]    ZERO_P   = {(K+2){1'b0}};
  localparam logic [LOGK-1:0] ZERO_L   = {LOGK{1'b0}};
  localparam logic [LOGK-1:0] ONE_L    = {{(LOGK-1){1'b0}}, 1'b1};
  localparam logic [LOGK-1:0] LAST_CNT = LOGK'(K-1);

  state_t          r_state;
  state_t          w_next;

  logic [K-1:0]    r_xr;
  logic [K-1:0]    r_yr;
  logic [K-1:0]    r_mr;
  logic [K-1:0]    r_acc;      // running result R
  logic [K+1:0]    r_p;        // multiplier partial product, always < 3m
  logic [LOGK-1:0] r_j;        // exponent bit pointer
  logic [LOGK-1:0] r_cnt;      // multiplier step counter 0..K-1
  logic [K-1:0]    r_z;
  logic            r_err;
  logic            r_done;
  logic            r_busy;

  logic            w_bad;
  logic            w_yzero;
  logic [LOGK-1:0] w_idx;
  logic            w_last;
  logic [LOGK-1:0] w_bit_idx;
  logic            w_abit;
  logic            w_ybit;
  logic            w_jzero;
  logic [K-1:0]    w_b;
  logic [K+1:0]    w_mr_ext;
  logic [K+1:0]    w_t0;
  logic [K+1:0]    w_t1;
  logic [K+1:0]    w_t2;
  logic [K-1:0]    w_prod;

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign z    = r_z;

  // Operand validity and trivial-exponent detection on the live inputs at accept
  assign w_bad   = (m <= ONE_K) || (x >= m);
  assign w_yzero = (y == ZERO_K);

  // Priority encoder: index of the most significant set bit of y
  always_comb begin
    w_idx = ZERO_L;
    for (int i = 0; i < K; i++) begin
      if (y[i]) begin
        w_idx = LOGK'(i);
      end else begin
        w_idx = w_idx;
      end
    end
  end

  // Multiplier step: scan a = R from its MSB; b is R (square) or xr (multiply)
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_bit_idx = LAST_CNT - r_cnt;
  assign w_abit    = |(r_acc & (ONE_K << w_bit_idx));
  assign w_ybit    = |(r_yr & (ONE_K << r_j));
  assign w_jzero   = (r_j == ZERO_L);
  assign w_b       = (r_state == S_MUL) ? r_xr : r_acc;
  assign w_mr_ext  = {2'b00, r_mr};
  assign w_t0      = (r_p << 1) + (w_abit ? {2'b00, w_b} : ZERO_P);
  assign w_t1      = (w_t0 >= w_mr_ext) ? (w_t0 - w_mr_ext) : w_t0;
  assign w_t2      = (w_t1 >= w_mr_ext) ? (w_t1 - w_mr_ext) : w_t1;
  assign w_prod    = w_t2[K-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic for the square/multiply sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad || w_yzero || (w_idx == ZERO_L)) begin
            w_next = S_FIN;
          end else begin
            w_next = S_SQR;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SQR: begin
        if (w_last) begin
          if (w_ybit) begin
            w_next = S_MUL;
          end else if (w_jzero) begin
            w_next = S_FIN;
          end else begin
            w_next = S_SQR;
          end
        end else begin
          w_next = S_SQR;
        end
      end
      S_MUL: begin
        if (w_last) begin
          if (w_jzero) begin
            w_next = S_FIN;
          end else begin
            w_next = S_SQR;
          end
        end else begin
          w_next = S_MUL;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, multiplier steps, result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xr   <= ZERO_K;
      r_yr   <= ZERO_K;
      r_mr   <= ZERO_K;
      r_acc  <= ZERO_K;
      r_p    <= ZERO_P;
      r_j    <= ZERO_L;
      r_cnt  <= ZERO_L;
      r_z    <= ZERO_K;
      r_err  <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (w_next == S_FIN);
      r_busy <= (w_next == S_SQR) || (w_next == S_MUL);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xr  <= x;
            r_yr  <= y;
            r_mr  <= m;
            r_acc <= x;
            r_p   <= ZERO_P;
            r_cnt <= ZERO_L;
            r_err <= w_bad;
            r_j   <= (w_idx == ZERO_L) ? ZERO_L : (w_idx - ONE_L);
            if (w_bad) begin
              r_z <= ZERO_K;
            end else if (w_yzero) begin
              r_z <= ONE_K;
            end else if (w_idx == ZERO_L) begin
              r_z <= x;
            end else begin
              r_z <= r_z;
            end
          end
        end
        S_SQR, S_MUL: begin
          if (w_last) begin
            // Product complete: fold into R and restart the multiplier
            r_acc <= w_prod;
            r_p   <= ZERO_P;
            r_cnt <= ZERO_L;
            if (w_next == S_FIN) begin
              r_z <= w_prod;
            end else if (w_next == S_SQR) begin
              r_j <= r_j - ONE_L;
            end else begin
              r_j <= r_j;
            end
          end else begin
            r_p   <= w_t2;
            r_cnt <= r_cnt + ONE_L;
          end
        end
        default: begin
          r_cnt <= ZERO_L;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_rtm.sv
// Directed bench for mod_exp_rtm: a K=8 instance for the functional, error,
// handshake and reset cases and a full-width K=196 instance for one run.
module tb_mod_exp_rtm;

  logic         clk;
  logic         rst;
  logic         start8;
  logic [7:0]   x8, y8, m8, z8;
  logic         busy8, done8, err8;
  logic         start_b;
  logic [195:0] x_b, y_b, m_b, z_b;
  logic         busy_b, done_b, err_b;

  int n_vec;
  int n_miss;

  mod_exp_rtm #(.K(8), .LOGK(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .m(m8),
    .busy(busy8), .done(done8), .err(err8), .z(z8)
  );

  mod_exp_rtm u_dut196 (
    .clk(clk), .rst(rst), .start(start_b), .x(x_b), .y(y_b), .m(m_b),
    .busy(busy_b), .done(done_b), .err(err_b), .z(z_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One K=8 operation; poke>0 pulses start with other operands at that cycle
  task automatic run8(input string tag, input logic [7:0] xx, input logic [7:0] yy,
                      input logic [7:0] mm, input logic [7:0] ez, input logic eerr,
                      input int elat, input int poke);
    int lat;
    int nbusy;
    @(negedge clk);
    x8 = xx; y8 = yy; m8 = mm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!done8 && lat < 2000) begin
      if (busy8) nbusy++;
      if (lat == poke) begin
        start8 = 1'b1; x8 = 8'd3; y8 = 8'd5; m8 = 8'd7;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    check_vec({tag, " done"}, {255'd0, done8}, 256'd1);
    check_vec({tag, " latency"}, lat, elat);
    check_vec({tag, " busy cycles"}, nbusy, elat - 1);
    check_vec({tag, " busy with done"}, {255'd0, busy8}, 256'd0);
    check_vec({tag, " z"}, {248'd0, z8}, {248'd0, ez});
    check_vec({tag, " err"}, {255'd0, err8}, {255'd0, eerr});
    @(posedge clk); #1;
    check_vec({tag, " done width"}, {255'd0, done8}, 256'd0);
  endtask

  initial begin
    int pulses;
    int wide;
    logic prev;
    int lat;
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    start8 = 1'b0; x8 = 8'd0; y8 = 8'd0; m8 = 8'd0;
    start_b = 1'b0; x_b = 196'd0; y_b = 196'd0; m_b = 196'd0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset z", {248'd0, z8}, 256'd0);
    check_vec("reset flags", {253'd0, busy8, done8, err8}, 256'd0);
    check_vec("reset z196", {60'd0, z_b}, 256'd0);
    @(negedge clk);
    rst = 1'b0;

    run8("2^11 mod 13",  8'd2,   8'd11,  8'd13,  8'd7,   1'b0, 41, 0);
    run8("2^2 mod 13",   8'd2,   8'd2,   8'd13,  8'd4,   1'b0, 9,  0);
    run8("5^1 mod 13",   8'd5,   8'd1,   8'd13,  8'd5,   1'b0, 1,  0);
    run8("5^0 mod 13",   8'd5,   8'd0,   8'd13,  8'd1,   1'b0, 1,  0);
    run8("fermat 251",   8'd3,   8'd250, 8'd251, 8'd1,   1'b0, 97, 0);
    run8("even mod 250", 8'd249, 8'd3,   8'd250, 8'd249, 1'b0, 17, 0);
    run8("err m=1",      8'd0,   8'd3,   8'd1,   8'd0,   1'b1, 1,  0);
    run8("err m=0",      8'd0,   8'd3,   8'd0,   8'd0,   1'b1, 1,  0);
    run8("err x=m",      8'd13,  8'd3,   8'd13,  8'd0,   1'b1, 1,  0);
    run8("err cleared",  8'd2,   8'd2,   8'd13,  8'd4,   1'b0, 9,  0);
    run8("start in SQR", 8'd2,   8'd11,  8'd13,  8'd7,   1'b0, 41, 12);

    // start held high: back-to-back runs of 2^2 mod 13, 10-cycle period
    @(negedge clk);
    x8 = 8'd2; y8 = 8'd2; m8 = 8'd13; start8 = 1'b1;
    pulses = 0;
    wide = 0;
    prev = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        if (prev) wide++;
        check_vec("held start z", {248'd0, z8}, 256'd4);
      end
      prev = done8;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    check_vec("held start pulses", pulses, 5);
    check_vec("held start wide pulses", wide, 0);

    // asynchronous reset in the middle of the first MUL of 2^11 mod 13
    @(negedge clk);
    x8 = 8'd2; y8 = 8'd11; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    check_vec("pre-reset busy", {255'd0, busy8}, 256'd1);
    rst = 1'b1;
    #1;
    check_vec("async reset z", {248'd0, z8}, 256'd0);
    check_vec("async reset flags", {253'd0, busy8, done8, err8}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    run8("after reset", 8'd2, 8'd11, 8'd13, 8'd7, 1'b0, 41, 0);

    // full width: m = 2^192 - 2^64 - 1, 2^11 = 2048, latency 1 + 196*5
    @(negedge clk);
    x_b = 196'd2;
    y_b = 196'd11;
    m_b = (196'd1 << 192) - (196'd1 << 64) - 196'd1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    check_vec("K196 latency", lat, 981);
    check_vec("K196 z", {60'd0, z_b}, 256'd2048);
    check_vec("K196 err", {255'd0, err_b}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mod_exp_rtm.md
Name: mod_exp_rtm

Overview:
- Runtime-modulus successor to the fixed-parameter modular exponentiator. Computes z = x^y mod m for any modulus m supplied on a port at start time.
- Needs no precomputed 2^2k constant and places no oddness restriction on m.
- Uses left-to-right binary square-and-multiply. Each modular product is built by an internal bit-serial interleaved modular multiplier at one multiplier bit per cycle.
- Sits in the RSA datapath as the top-level exponentiation engine, driven by a start/done handshake.

Parameters:
- K, 196: operand width in bits for x, y, m, z.
- LOGK, 8: width of internal bit pointers and counters; 2^LOGK >= K is required.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- x  in  K  base; sampled on the accepted start edge.
- y  in  K  exponent; sampled on the accepted start edge.
- m  in  K  modulus; sampled on the accepted start edge.
- busy  out  1  high from the cycle after the accepted start until done is high.
- done  out  1  one-cycle completion pulse.
- err  out  1  operand error flag, valid with done, held until next accept.
- z  out  K  result, valid with done, held until next accept.

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; z=0, done=0, busy=0, err=0; all internal registers cleared. The in-flight result is discarded.
- Accept: rising edge with state IDLE and start=1. Latch x, y, m into xr, yr, mr. start is ignored in any other state, and the latched operands do not change. start held high re-triggers a new operation in the cycle after done.
- Validity check at accept (combinational on inputs):
  - m<=1 or x>=m: go to FIN with err=1, z=0.
  - y==0 (operands valid): go to FIN with z=1.
  - Otherwise: idx = index of the most significant set bit of y (priority encoder); R <= x; j <= idx-1; go to FIN if idx==0, else go to SQR.
- States: IDLE, SQR, MUL, FIN.
- SQR: run modmul(R,R) for K cycles, then R <= product.
  - If yr[j]=1: go to MUL.
  - Else if j==0: go to FIN.
  - Else: j <= j-1, stay in SQR.
- MUL: run modmul(R,xr) for K cycles, then R <= product.
  - If j==0: go to FIN.
  - Else: j <= j-1, go to SQR.
- FIN: lasts 1 cycle. done=1, busy=0, z=R (or the error/unity value). Then go to IDLE.
- done and busy are Moore outputs (registered state decode). done is never high for more than one cycle.
- Interleaved modmul(a,b), with P cleared at multiplier start and i from K-1 down to 0, one step per cycle:
  - P <= 2P + (a[i] ? b : 0), then subtract mr up to twice while P>=mr.
  - P register is K+2 bits wide, because the intermediate value is < 3m.
  - Result is < mr and is truncated to K bits.
- Internal bit counter: LOGK bits, counts 0..K-1, and restarts on each SQR/MUL entry.
- Latency from the accept edge to the first cycle with done=1:
  - valid y>0: 1 + K*(idx + popcount(y) - 1) cycles.
  - error or y==0: 1 cycle.
- busy is never high in the same cycle as done. No back-to-back overlap: the next accept happens no earlier than the cycle after FIN.

Test Plan:
- K=8, LOGK=4, m=13, x=2, y=11 -> done after 1+8*(3+2)=41 cycles, z=7, err=0. busy high for 40 cycles, done high for 1 cycle.
- K=8, m=13, x=2, y=2 -> z=4 after 9 cycles. Then y=1, x=5 -> z=5 after 1 cycle. Then y=0, x=5 -> z=1 after 1 cycle.
- K=8, m=251, x=3, y=250 -> z=1 (Fermat) after 1+8*(7+5)=97 cycles. Also m=250, x=249, y=3 -> z=249 after 1+8*(1+1)=17 cycles, which checks that even moduli are accepted.
- Error cases, K=8:
  - m=1 -> err=1, z=0, latency 1.
  - m=0 -> err=1, z=0, latency 1.
  - m=13, x=13 -> err=1, z=0, latency 1.
  - Each pulses done once; the next valid run clears err.
- Handshake: pulse start with new operands while busy (mid-SQR of the x=2, y=11 run) -> ignored, result still z=7. Hold start high continuously -> consecutive runs, each done exactly one cycle wide.
- Reset: assert rst asynchronously, between clock edges, mid-MUL -> z, done, busy, err go to 0 immediately. After release, x=2, y=11, m=13 completes normally with z=7. Also K=196, m=2^192-2^64-1, x=2, y=11 -> z=2048.
